// File: rtl/pcs_vol_pkg.sv
// Shared types and constants for the per-domain voltage-scale handshake blocks.
package pcs_vol_pkg;

  localparam int VOL_W = 3;

  typedef logic [VOL_W-1:0] vol_level_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    REL   = 2'd2,
    ABORT = 2'd3
  } vol_state_e;

  localparam vol_level_t VOL_LEVEL_MIN = 3'd0;
  localparam vol_level_t VOL_LEVEL_MAX = 3'd7;

endpackage

// File: rtl/vol_ack_sync.sv
// Reset-to-0 flop chain bringing a 32 kHz-domain status bit into pclk.
module vol_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic prst,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
  always_ff @(posedge pclk) begin
    if (prst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcs_vol_scale_initiator.sv
// Four-phase req/ack initiator toward a power domain's voltage controller.
// Optional per-phase timeout and ABORT state are built when PCS_VOL_TIMEOUT_EN is defined.
module pcs_vol_scale_initiator
  import pcs_vol_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter vol_level_t RESET_LEVEL    = VOL_LEVEL_MIN
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [VOL_W-1:0] cmd_level,
  output logic             done_valid,
  output logic             done_err,
  output logic             busy,
  output logic [VOL_W-1:0] cur_level,
  output logic             pcs_vol_scale_req,
  output logic [VOL_W-1:0] pcs_vol_scale,
  input  logic             pcs_vol_scale_ack
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("pcs_vol_scale_initiator: SYNC_STAGES and TIMEOUT_CYCLES must be at least 2");
  end

  vol_state_e state_q, state_d;
  logic       ack_s;
  logic       accept;
  logic       done_valid_d;
  vol_level_t cur_level_d;
  vol_level_t vol_d;

  vol_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .pclk     (pclk),
    .prst     (prst),
    .async_in (pcs_vol_scale_ack),
    .sync_out (ack_s)
  );

  // A stale high ack means the responder has not returned to zero yet.
  assign cmd_ready = (state_q == IDLE) && !ack_s;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);

`ifdef PCS_VOL_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_err_d;
  logic             expired;

  assign expired = (cnt_q == CNT_LAST);
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    done_valid_d = 1'b0;
    cur_level_d  = cur_level;
    vol_d        = pcs_vol_scale;
`ifdef PCS_VOL_TIMEOUT_EN
    done_err_d   = 1'b0;
    cnt_d        = cnt_q;
    if ((state_q == REQ || state_q == REL) && cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_level == cur_level) begin
            done_valid_d = 1'b1;
          end else begin
            vol_d   = cmd_level;
            state_d = REQ;
`ifdef PCS_VOL_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      REQ: begin
        if (ack_s) begin
          cur_level_d = pcs_vol_scale;
          state_d     = REL;
`ifdef PCS_VOL_TIMEOUT_EN
          cnt_d       = '0;
        end else if (expired) begin
          state_d     = ABORT;
`endif
        end
      end
      REL: begin
        if (!ack_s) begin
          done_valid_d = 1'b1;
          state_d      = IDLE;
`ifdef PCS_VOL_TIMEOUT_EN
        end else if (expired) begin
          // Level already committed; only the release phase failed.
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          state_d      = IDLE;
`endif
        end
      end
      ABORT: begin
`ifdef PCS_VOL_TIMEOUT_EN
        if (!ack_s) begin
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          state_d      = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q           <= IDLE;
      pcs_vol_scale_req <= 1'b0;
      pcs_vol_scale     <= RESET_LEVEL;
      cur_level         <= RESET_LEVEL;
      done_valid        <= 1'b0;
    end else begin
      state_q           <= state_d;
      pcs_vol_scale_req <= (state_d == REQ);
      pcs_vol_scale     <= vol_d;
      cur_level         <= cur_level_d;
      done_valid        <= done_valid_d;
    end
  end

`ifdef PCS_VOL_TIMEOUT_EN
  always_ff @(posedge pclk) begin
    if (prst) begin
      cnt_q    <= '0;
      done_err <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      done_err <= done_err_d;
    end
  end
`else
  assign done_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_vol_scale_initiator.sv
// Self-checking bench for pcs_vol_scale_initiator with a behavioural voltage-controller responder.
module tb_pcs_vol_scale_initiator;
  import pcs_vol_pkg::*;

  localparam int         SYNC_STAGES    = 2;
  localparam int         TIMEOUT_CYCLES = 16;
  localparam vol_level_t RESET_LEVEL    = 3'd0;
  localparam int         BASE_LAT       = 2 * (SYNC_STAGES + 1) + 2;

  typedef enum int {RESP_FOLLOW, RESP_SILENT, RESP_STUCK, RESP_FORCE} resp_mode_e;

  typedef struct {
    vol_level_t lvl;
    int         dly;
    logic       hs;
    int         lat;
    vol_level_t cur;
  } vec_t;

  logic       pclk      = 1'b0;
  logic       prst      = 1'b1;
  logic       cmd_valid = 1'b0;
  vol_level_t cmd_level = '0;
  logic       cmd_ready;
  logic       done_valid;
  logic       done_err;
  logic       busy;
  vol_level_t cur_level;
  logic       req;
  vol_level_t pcs_vol_scale;
  logic       ack       = 1'b1;

  resp_mode_e resp_mode = RESP_FORCE;
  logic       force_val = 1'b1;
  int         resp_dly  = 0;
  int         wait_cnt  = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int done_pulses = 0;
  int done_expected = 0;
  vol_level_t model_cur;

  pcs_vol_scale_initiator #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .RESET_LEVEL    (RESET_LEVEL)
  ) dut (
    .pclk              (pclk),
    .prst              (prst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_level         (cmd_level),
    .done_valid        (done_valid),
    .done_err          (done_err),
    .busy              (busy),
    .cur_level         (cur_level),
    .pcs_vol_scale_req (req),
    .pcs_vol_scale     (pcs_vol_scale),
    .pcs_vol_scale_ack (ack)
  );

  always #5 pclk = ~pclk;

  // Responder: follows req after resp_dly extra cycles, or misbehaves on demand.
  always @(posedge pclk) begin
    case (resp_mode)
      RESP_FOLLOW: begin
        if (ack != req) begin
          if (wait_cnt >= resp_dly) begin
            ack <= req;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
      RESP_SILENT: ack <= 1'b0;
      RESP_STUCK:  if (req) ack <= 1'b1;
      default:     ack <= force_val;
    endcase
  end

  always @(negedge pclk) if (done_valid) done_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Issues one command at a negedge and waits (bounded) for its done pulse.
  task automatic run_cmd(input string tag, input vol_level_t lvl, input int dly, input logic exp_hs,
                         input int exp_lat, input logic exp_err, input vol_level_t exp_cur,
                         input logic exp_ready);
    int t;
    int k;
    resp_dly = dly;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge pclk);
      t++;
    end
    check({tag, " ready"}, cmd_ready, 1);
    cmd_level = lvl;
    cmd_valid = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
    check({tag, " req@accept"}, req, exp_hs);
    check({tag, " busy@accept"}, busy, exp_hs);
    if (exp_hs) check({tag, " target"}, pcs_vol_scale, lvl);
    k = 0;
    while (done_valid !== 1'b1 && k < 400) begin
      @(negedge pclk);
      k++;
    end
    check({tag, " latency"}, k, exp_lat);
    check({tag, " err"}, done_err, exp_err);
    check({tag, " cur_level"}, cur_level, exp_cur);
    check({tag, " ready@done"}, cmd_ready, exp_ready);
    done_expected++;
  endtask

  initial begin
    vec_t       vecs[7];
    int         t;
    vol_level_t lvl;

    vecs[0] = '{lvl: 3'd5, dly: 0, hs: 1'b1, lat: 8,  cur: 3'd5};
    vecs[1] = '{lvl: 3'd5, dly: 0, hs: 1'b0, lat: 0,  cur: 3'd5};
    vecs[2] = '{lvl: 3'd3, dly: 2, hs: 1'b1, lat: 12, cur: 3'd3};
    vecs[3] = '{lvl: 3'd3, dly: 1, hs: 1'b0, lat: 0,  cur: 3'd3};
    vecs[4] = '{lvl: 3'd0, dly: 1, hs: 1'b1, lat: 10, cur: 3'd0};
    vecs[5] = '{lvl: 3'd7, dly: 3, hs: 1'b1, lat: 14, cur: 3'd7};
    vecs[6] = '{lvl: 3'd6, dly: 0, hs: 1'b1, lat: 8,  cur: 3'd6};

    // Reset held with a stale high ack from the responder.
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset req", req, 0);
    check("reset pcs_vol_scale", pcs_vol_scale, RESET_LEVEL);
    check("reset cur_level", cur_level, RESET_LEVEL);
    check("reset done_valid", done_valid, 0);
    check("reset done_err", done_err, 0);
    check("reset busy", busy, 0);
    prst = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge pclk);
    check("stale ack blocks ready", cmd_ready, 0);
    check("stale ack busy", busy, 0);
    force_val = 1'b0;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge pclk);
      t++;
    end
    check("ready after ack falls", cmd_ready, 1);
    resp_mode = RESP_FOLLOW;
    model_cur = RESET_LEVEL;

    for (int i = 0; i < 7; i++) begin
      run_cmd("vector", vecs[i].lvl, vecs[i].dly, vecs[i].hs, vecs[i].lat, 1'b0, vecs[i].cur, 1'b1);
      model_cur = vecs[i].cur;
    end

`ifdef PCS_VOL_TIMEOUT_EN
    resp_mode = RESP_SILENT;
    lvl = model_cur + 3'd1;
    run_cmd("req timeout", lvl, 0, 1'b1, TIMEOUT_CYCLES + 1, 1'b1, model_cur, 1'b1);
    resp_mode = RESP_STUCK;
    lvl = model_cur + 3'd2;
    run_cmd("rel timeout", lvl, 0, 1'b1, SYNC_STAGES + 2 + TIMEOUT_CYCLES, 1'b1, lvl, 1'b0);
    model_cur = lvl;
    resp_mode = RESP_FOLLOW;
`endif

    // Reset two cycles into REQ.
    resp_dly = 0;
    lvl = model_cur ^ 3'd5;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge pclk);
      t++;
    end
    check("midreset ready", cmd_ready, 1);
    cmd_level = lvl;
    cmd_valid = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("midreset req up", req, 1);
    @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    check("midreset req", req, 0);
    check("midreset pcs_vol_scale", pcs_vol_scale, RESET_LEVEL);
    check("midreset cur_level", cur_level, RESET_LEVEL);
    check("midreset busy", busy, 0);
    prst = 1'b0;
    model_cur = RESET_LEVEL;
    repeat (SYNC_STAGES + 3) @(negedge pclk);
    run_cmd("post-reset", 3'd4, 0, 1'b1, BASE_LAT, 1'b0, 3'd4, 1'b1);
    model_cur = 3'd4;

    // Randomized commands against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int         d;
      vol_level_t l;
      logic       hs;
      d  = int'($urandom_range(0, 3));
      l  = ($urandom_range(0, 2) == 0) ? model_cur
                                       : vol_level_t'($urandom_range(0, int'(VOL_LEVEL_MAX)));
      hs = (l != model_cur);
      run_cmd("random", l, d, hs, hs ? BASE_LAT + 2 * d : 0, 1'b0, l, 1'b1);
      model_cur = l;
    end

    repeat (3) @(negedge pclk);
    check("done pulse count", done_pulses, done_expected);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
